// File: rtl/pair_mon_pkg.sv
// Shared types and helpers for the pair capture monitor.
// Snapshot struct uses the default count width; the top re-declares it at its own CNT_W.
package pair_mon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CNT_W_DEF  = 8;
    localparam int WINDOW_DEF = 16;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] edge1;
        logic [CNT_W_DEF-1:0] edge2;
        logic [CNT_W_DEF-1:0] coinc;
    } snap_t;

    function automatic int win_w(input int window);
        return $clog2(window);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter. count_next is the value including this cycle's
// increment, so a window-end snapshot can capture it before the clear lands.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_reg;

    assign count_next = (inc && (count_reg != CNT_MAX)) ? count_reg + CNT_W'(1) : count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/pair_capture_monitor.sv
// Windowed edge/coincidence monitor on the registered q1/q2 capture outputs.
// Define PAIR_MON_COINC_EN to build the coincidence counter; otherwise snap_coinc is 0.
module pair_capture_monitor
    import pair_mon_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q1,
    input  logic             q2,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             snap_ready,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap_edge1,
    output logic [CNT_W-1:0] snap_edge2,
    output logic [CNT_W-1:0] snap_coinc,
    output logic             overflow,
    output logic             busy
);

    localparam int WIN_W = win_w(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
`ifdef PAIR_MON_COINC_EN
    localparam int NUM_CNT = 3;
`else
    localparam int NUM_CNT = 2;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] edge1;
        logic [CNT_W-1:0] edge2;
        logic [CNT_W-1:0] coinc;
    } cnt_snap_t;

    state_t           state_reg, state_next;
    logic             q1_d_reg, q2_d_reg;
    logic [WIN_W-1:0] win_reg, win_next;
    logic             snap_valid_reg, snap_valid_next;
    logic             overflow_reg, overflow_next;
    cnt_snap_t        snap_reg, snap_next;

    logic             run;
    logic             win_end;
    logic             cnt_clear;
    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_upd [NUM_CNT];

    assign run       = (state_reg == RUN);
    assign win_end   = run && (win_reg == WIN_LAST);
    // Live counts restart on every window end as well as on stop or clr.
    assign cnt_clear = clr | win_end | (run & stop);

    assign cnt_inc[0] = run & q1 & ~q1_d_reg;
    assign cnt_inc[1] = run & q2 & ~q2_d_reg;
`ifdef PAIR_MON_COINC_EN
    assign cnt_inc[2] = run & q1 & q2;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc       (cnt_inc[gi]),
                .clear     (cnt_clear),
                .count_next(cnt_upd[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (start) state_next = RUN;
                RUN:     if (stop)  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        win_next = '0;
        if (!clr && run && !win_end && !stop) begin
            win_next = win_reg + WIN_W'(1);
        end
    end

    always_comb begin
        snap_valid_next = snap_valid_reg;
        overflow_next   = overflow_reg;
        snap_next       = snap_reg;
        if (clr) begin
            snap_valid_next = 1'b0;
            overflow_next   = 1'b0;
            snap_next       = '0;
        end else if (win_end) begin
            // A pending snapshot wins over fresh data unless it is being taken now.
            if (!snap_valid_reg || snap_ready) begin
                snap_next.edge1 = cnt_upd[0];
                snap_next.edge2 = cnt_upd[1];
`ifdef PAIR_MON_COINC_EN
                snap_next.coinc = cnt_upd[2];
`else
                snap_next.coinc = '0;
`endif
                snap_valid_next = 1'b1;
            end else begin
                overflow_next = 1'b1;
            end
        end else if (snap_valid_reg && snap_ready) begin
            snap_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            q1_d_reg       <= 1'b0;
            q2_d_reg       <= 1'b0;
            win_reg        <= '0;
            snap_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            snap_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            q1_d_reg       <= q1;
            q2_d_reg       <= q2;
            win_reg        <= win_next;
            snap_valid_reg <= snap_valid_next;
            overflow_reg   <= overflow_next;
            snap_reg       <= snap_next;
        end
    end

    assign snap_valid = snap_valid_reg;
    assign snap_edge1 = snap_reg.edge1;
    assign snap_edge2 = snap_reg.edge2;
    assign snap_coinc = snap_reg.coinc;
    assign overflow   = overflow_reg;
    assign busy       = run;

endmodule
